// File: rtl/ks_pkg.sv
// ks_pkg -- shared definitions for the pipelined Kogge-Stone adder.
//   gp_t    : (generate, propagate) pair carried through the prefix tree
//   clog2   : ceiling log2, used to size the prefix tree
//   nstage  : number of register stages after the operand stage,
//             ceil(log2w / lvl_per_stage)
package ks_pkg;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   function automatic int nstage(input int log2w, input int lvl_per_stage);
      return (log2w + lvl_per_stage - 1) / lvl_per_stage;
   endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// ks_prefix_level -- one combinational level of a Kogge-Stone prefix tree.
//   gp_in  : WIDTH (G,P) pairs entering level K
//   gp_out : WIDTH (G,P) pairs leaving level K
// Bit i merges with bit i-2^K; bits below 2^K already hold their complete
// group [i:0] and pass through unchanged.
module ks_prefix_level
   import ks_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int K     = 0
) (
   input  gp_t [WIDTH-1:0] gp_in,
   output gp_t [WIDTH-1:0] gp_out
);

   localparam int DIST = 1 << K;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         if (gi >= DIST) begin : g_merge
            assign gp_out[gi].g = gp_in[gi].g | (gp_in[gi].p & gp_in[gi-DIST].g);
            assign gp_out[gi].p = gp_in[gi].p & gp_in[gi-DIST].p;
         end else begin : g_pass
            assign gp_out[gi] = gp_in[gi];
         end
      end
   endgenerate

endmodule

// File: rtl/pipelined_ks_adder.sv
// pipelined_ks_adder -- pipelined Kogge-Stone adder/subtractor with a
// valid/ready handshake on both sides.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand beat handshake (in_ready = advance enable)
//   a, b, cin, sub      : operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready : result beat handshake
//   s, cout, ovf, zero  : result, carry out (0 = borrow on subtract),
//                         signed overflow, result-is-zero
// Stage 0 registers the bitwise g/p terms. The prefix levels follow, with a
// register inserted every LVL_PER_STAGE levels; the last group of levels
// feeds the final carry/sum logic directly into the output register.
module pipelined_ks_adder
   import ks_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int LVL_PER_STAGE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int LOG2W  = clog2(WIDTH);
   localparam int NSTAGE = nstage(LOG2W, LVL_PER_STAGE);
   localparam int LAST   = LOG2W - 1;

   logic             en;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   gp_t  [WIDTH-1:0] gp_first;

   // Stage 0 registers
   gp_t  [WIDTH-1:0] s0_gp_reg;
   logic [WIDTH-1:0] s0_p0_reg;
   logic             s0_cin_reg;
   logic             s0_vld_reg;

   // Per-level view of the pipeline: what enters each prefix level, plus the
   // side-band values (bitwise propagate, carry-in, valid) travelling with it.
   gp_t  [WIDTH-1:0] lvl_in  [0:LOG2W-1];
   gp_t  [WIDTH-1:0] lvl_out [0:LOG2W-1];
   logic [WIDTH-1:0] p0_in   [0:LOG2W-1];
   logic             cin_in  [0:LOG2W-1];
   logic             vld_in  [0:LOG2W-1];

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_next;

   // The whole pipe moves together; it only stops when a result is waiting
   // for a consumer that is not ready.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // Subtract is a + ~b + 1, so the forced carry-in replaces cin.
   assign b_eff   = sub ? ~b : b;
   assign cin_eff = sub | cin;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_gp
         assign gp_first[gi].g = a[gi] & b_eff[gi];
         assign gp_first[gi].p = a[gi] ^ b_eff[gi];
      end
   endgenerate

   // Data registers are left unreset; only valid bits need a known state.
   always_ff @(posedge clk) begin
      if (en) begin
         s0_gp_reg  <= gp_first;
         s0_p0_reg  <= a ^ b_eff;
         s0_cin_reg <= cin_eff;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_vld_reg <= 1'b0;
      end else if (en) begin
         s0_vld_reg <= in_valid;
      end
   end

   assign lvl_in[0] = s0_gp_reg;
   assign p0_in[0]  = s0_p0_reg;
   assign cin_in[0] = s0_cin_reg;
   assign vld_in[0] = s0_vld_reg;

   generate
      for (gi = 0; gi < LOG2W; gi++) begin : g_level
         ks_prefix_level #(
            .WIDTH (WIDTH),
            .K     (gi)
         ) u_level (
            .gp_in  (lvl_in[gi]),
            .gp_out (lvl_out[gi])
         );

         if (gi > 0) begin : g_link
            // A register closes each full group of LVL_PER_STAGE levels; the
            // final (possibly shorter) group ends at the output register.
            if ((gi % LVL_PER_STAGE) == 0 && (gi / LVL_PER_STAGE) < NSTAGE) begin : g_reg
               gp_t  [WIDTH-1:0] gp_reg;
               logic [WIDTH-1:0] p0_reg;
               logic             cin_reg;
               logic             vld_reg;

               always_ff @(posedge clk) begin
                  if (en) begin
                     gp_reg  <= lvl_out[gi-1];
                     p0_reg  <= p0_in[gi-1];
                     cin_reg <= cin_in[gi-1];
                  end
               end

               always_ff @(posedge clk or posedge rst) begin
                  if (rst) begin
                     vld_reg <= 1'b0;
                  end else if (en) begin
                     vld_reg <= vld_in[gi-1];
                  end
               end

               assign lvl_in[gi] = gp_reg;
               assign p0_in[gi]  = p0_reg;
               assign cin_in[gi] = cin_reg;
               assign vld_in[gi] = vld_reg;
            end else begin : g_wire
               assign lvl_in[gi] = lvl_out[gi-1];
               assign p0_in[gi]  = p0_in[gi-1];
               assign cin_in[gi] = cin_in[gi-1];
               assign vld_in[gi] = vld_in[gi-1];
            end
         end
      end
   endgenerate

   // After the last level each position holds the group (G,P) over [i:0],
   // so the carry into bit i+1 folds in the carry-in directly.
   assign carry[0] = cin_in[LAST];
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_carry
         assign carry[gi+1] = lvl_out[LAST][gi].g | (lvl_out[LAST][gi].p & cin_in[LAST]);
      end
   endgenerate

   assign sum_next = p0_in[LAST] ^ carry[WIDTH-1:0];

   // Result fields only load with a valid beat, so they stay put across
   // bubbles as well as stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         s         <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
      end else if (en) begin
         out_valid <= vld_in[LAST];
         if (vld_in[LAST]) begin
            s    <= sum_next;
            cout <= carry[WIDTH];
            ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
            zero <= (sum_next == '0);
         end
      end
   end

endmodule

// File: tb/tb_pipelined_ks_adder.sv
// Testbench for pipelined_ks_adder: directed checks on an 8-bit instance,
// randomized handshake runs on 32-bit and 64-bit instances against an
// arithmetic reference model.
module tb_pipelined_ks_adder;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   // 8-bit instance, one prefix level per stage
   logic       iv8, ordy8, cin8, sub8;
   logic [7:0] a8, b8;
   wire        ir8, ov8, co8, of8, z8;
   wire  [7:0] s8;

   pipelined_ks_adder #(.WIDTH(8), .LVL_PER_STAGE(1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(ordy8), .s(s8),
      .cout(co8), .ovf(of8), .zero(z8)
   );

   // Shared random drivers for the wide instances; sel picks the active one.
   logic [63:0] ra, rb;
   logic        rcin, rsub, riv, rordy;
   int          sel = 0;
   wire         iv32 = riv && (sel == 32);
   wire         iv64 = riv && (sel == 64);
   wire         ir32, ov32, co32, of32, z32;
   wire  [31:0] s32;
   wire         ir64, ov64, co64, of64, z64;
   wire  [63:0] s64;

   pipelined_ks_adder #(.WIDTH(32), .LVL_PER_STAGE(2)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(ra[31:0]),
      .b(rb[31:0]), .cin(rcin), .sub(rsub), .out_valid(ov32), .out_ready(rordy),
      .s(s32), .cout(co32), .ovf(of32), .zero(z32)
   );

   pipelined_ks_adder #(.WIDTH(64), .LVL_PER_STAGE(4)) dut64 (
      .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(ra), .b(rb),
      .cin(rcin), .sub(rsub), .out_valid(ov64), .out_ready(rordy),
      .s(s64), .cout(co64), .ovf(of64), .zero(z64)
   );

   logic        r_ir, r_ov, r_co, r_of, r_z;
   logic [63:0] r_s;
   always_comb begin
      if (sel == 32) begin
         r_ir = ir32; r_ov = ov32; r_co = co32; r_of = of32; r_z = z32;
         r_s  = {32'b0, s32};
      end else begin
         r_ir = ir64; r_ov = ov64; r_co = co64; r_of = of64; r_z = z64;
         r_s  = s64;
      end
   end

   // Reference: {cout, ovf, zero, s[63:0]} from plain arithmetic.
   function automatic logic [66:0] model(input int w, input logic [63:0] a,
                                         input logic [63:0] b, input logic cin,
                                         input logic sub);
      logic [64:0] full;
      logic [63:0] mask, sum;
      logic        co, ov, sa, sb, ss;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      if (sub) begin
         full = {1'b0, a} - {1'b0, b};
         co   = (a >= b);
      end else begin
         full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
         co   = full[w];
      end
      sum = full[63:0] & mask;
      sa  = a[w-1];
      sb  = b[w-1];
      ss  = sum[w-1];
      ov  = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
      return {co, ov, (sum == 64'd0), sum};
   endfunction

   task automatic test_reset();
      rst = 1'b1; iv8 = 1'b0; ordy8 = 1'b1; riv = 1'b0; rordy = 1'b1;
      a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
      ra = '0; rb = '0; rcin = 1'b0; rsub = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({ov8, s8, co8, of8, z8} !== 12'd0) begin
         bad++;
         $display("FAIL reset_outputs: got ov/s/co/ov/z=%b want all zero", {ov8, s8, co8, of8, z8});
      end
      total++;
      if (ir8 !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready: got %b want 1", ir8);
      end
      total++;
      if ({ov32, ov64} !== 2'b00) begin
         bad++;
         $display("FAIL reset_wide_valid: got %b want 00", {ov32, ov64});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      $display("test_reset: done");
   endtask

   task automatic test_vectors();
      logic [7:0] ta [5] = '{8'h96, 8'h27, 8'h00, 8'h80, 8'hFF};
      logic [7:0] tb [5] = '{8'hCA, 8'h9B, 8'h01, 8'h01, 8'h01};
      logic       tc [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       tsb[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [7:0] es [5] = '{8'h60, 8'hC3, 8'hFF, 8'h7F, 8'h00};
      logic [2:0] ef [5] = '{3'b110, 3'b000, 3'b000, 3'b110, 3'b101}; // cout,ovf,zero
      int lat;
      ordy8 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         a8 = ta[i]; b8 = tb[i]; cin8 = tc[i]; sub8 = tsb[i]; iv8 = 1'b1;
         lat = 0;
         do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) iv8 = 1'b0;
         end while (!ov8 && lat < 12);
         total++;
         if (lat !== 4) begin
            bad++;
            $display("FAIL vec%0d latency: got %0d want 4", i, lat);
         end
         total++;
         if ({s8, co8, of8, z8} !== {es[i], ef[i]}) begin
            bad++;
            $display("FAIL vec%0d result: got s=%h c/o/z=%b%b%b want s=%h c/o/z=%b",
                     i, s8, co8, of8, z8, es[i], ef[i]);
         end
         $display("vector %0d: a=%h b=%h cin=%b sub=%b -> s=%h cout=%b ovf=%b zero=%b lat=%0d",
                  i, ta[i], tb[i], tc[i], tsb[i], s8, co8, of8, z8, lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [66:0] q[$];
      logic [66:0] exp_r;
      logic [10:0] act, held;
      logic        hold_prev;
      int          sent, got;
      sent = 0; got = 0; hold_prev = 1'b0; held = '0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         iv8   = (sent < 8);
         a8    = 8'($urandom); b8 = 8'($urandom);
         cin8  = 1'($urandom); sub8 = 1'($urandom);
         ordy8 = !(c >= 6 && c <= 8);
         @(negedge clk);
         act = {co8, of8, z8, s8};
         if (hold_prev) begin
            total++;
            if (act !== held || ov8 !== 1'b1) begin
               bad++;
               $display("FAIL b2b_stable c=%0d: got v=%b %h want v=1 %h", c, ov8, act, held);
            end
         end
         if (!ordy8 && ov8) begin
            total++;
            if (ir8 !== 1'b0) begin
               bad++;
               $display("FAIL b2b_in_ready c=%0d: got %b want 0", c, ir8);
            end
         end
         if (c >= 9 && got < 8) begin
            total++;
            if (ov8 !== 1'b1) begin
               bad++;
               $display("FAIL b2b_rate c=%0d: got out_valid %b want 1", c, ov8);
            end
         end
         if (ov8 && ordy8) begin
            total++;
            exp_r = (q.size() > 0) ? q.pop_front() : '1;
            if (act !== {exp_r[66:64], exp_r[7:0]}) begin
               bad++;
               $display("FAIL b2b_result %0d: got %h want %h", got, act, {exp_r[66:64], exp_r[7:0]});
            end
            $display("b2b result %0d: s=%h cout=%b ovf=%b zero=%b", got, s8, co8, of8, z8);
            got++;
         end
         hold_prev = ov8 && !ordy8;
         held      = act;
         if (iv8 && ir8) begin
            q.push_back(model(8, {56'd0, a8}, {56'd0, b8}, cin8, sub8));
            sent++;
         end
         @(posedge clk); #1;
      end
      iv8 = 1'b0; ordy8 = 1'b1;
      total++;
      if (got !== 8) begin
         bad++;
         $display("FAIL b2b_count: got %0d results want 8", got);
      end
   endtask

   task automatic test_reset_midflight();
      int n;
      ordy8 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'b0;
         iv8 = 1'b1;
         @(posedge clk); #1;
      end
      iv8 = 1'b0;
      n = 0;
      while (!ov8 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (ov8 !== 1'b1) begin
         bad++;
         $display("FAIL midrst_setup: got out_valid %b want 1", ov8);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({ov8, ir8} !== 2'b01) begin
         bad++;
         $display("FAIL midrst_immediate: got out_valid/in_ready=%b want 01", {ov8, ir8});
      end
      @(posedge clk); #1;
      rst = 1'b0; ordy8 = 1'b1;
      n = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (ov8) n++;
         @(posedge clk); #1;
      end
      total++;
      if (n !== 0) begin
         bad++;
         $display("FAIL midrst_ghost: got %0d stale results want 0", n);
      end
      $display("reset mid-flight: stale results seen=%0d", n);
   endtask

   task automatic test_random(input int w, input int nbeats);
      logic [66:0] q[$];
      logic [66:0] exp_r, act, held;
      logic [63:0] mask;
      logic        hold_prev;
      int          sent, got, cyc;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      sel = w; sent = 0; got = 0; hold_prev = 1'b0; held = '0;
      for (cyc = 0; cyc < 40000 && got < nbeats; cyc++) begin
         riv   = (sent < nbeats) && ($urandom_range(3) != 0);
         ra    = {$urandom, $urandom} & mask;
         rb    = ($urandom_range(7) == 0) ? ra : ({$urandom, $urandom} & mask);
         rcin  = 1'($urandom);
         rsub  = 1'($urandom);
         rordy = ($urandom_range(3) != 0);
         @(negedge clk);
         act = {r_co, r_of, r_z, r_s};
         total++;
         if (r_ir !== (!r_ov || rordy)) begin
            bad++;
            $display("FAIL rand%0d in_ready cyc=%0d: got %b want %b", w, cyc, r_ir, (!r_ov || rordy));
         end
         if (hold_prev) begin
            total++;
            if (act !== held || r_ov !== 1'b1) begin
               bad++;
               $display("FAIL rand%0d stable cyc=%0d: got v=%b %h want v=1 %h", w, cyc, r_ov, act, held);
            end
         end
         if (r_ov && rordy) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL rand%0d extra cyc=%0d: got %h want no result", w, cyc, act);
            end else begin
               exp_r = q.pop_front();
               if (act !== exp_r) begin
                  bad++;
                  $display("FAIL rand%0d result %0d: got %h want %h", w, got, act, exp_r);
               end
            end
            got++;
         end
         hold_prev = r_ov && !rordy;
         held      = act;
         if (riv && r_ir) begin
            q.push_back(model(w, ra, rb, rcin, rsub));
            sent++;
         end
         @(posedge clk); #1;
      end
      riv = 1'b0; rordy = 1'b1;
      total++;
      if (got !== nbeats) begin
         bad++;
         $display("FAIL rand%0d count: got %0d results want %0d", w, got, nbeats);
      end
      $display("random run width=%0d: beats=%0d cycles=%0d", w, got, cyc);
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back();
      test_reset_midflight();
      test_random(32, 10000);
      test_random(64, 10000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
